// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the execute-stage branch resolver.
// Holds the branch funct3 encodings and the redirect FSM state type.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } br_state_t;

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating up-counter: increments by one per cycle with inc high and sticks at all-ones.
// Synchronous active-high reset to zero.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + ONE;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves branches/JAL/JALR in EX, issues a registered PC redirect to fetch and flushes IF/ID.
// Redirect is held (with EX stalled) until fetch accepts; FLUSH_CYCLES bubbles then follow.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  ex_is_branch,
    input  logic                  ex_is_jal,
    input  logic                  ex_is_jalr,
    input  logic [2:0]            ex_funct3,
    input  logic [DATA_WIDTH-1:0] ex_target,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic                  Zero,
    input  logic                  N,
    input  logic                  C,
    input  logic                  V,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_ready,
    output logic                  target_misalign,
    output logic                  flush,
    output logic                  stall_ex,
    output logic                  illegal_branch,
    output logic [CNT_WIDTH-1:0]  branch_count,
    output logic [CNT_WIDTH-1:0]  taken_count
);

    br_state_t             state_q, state_d;
    logic [2:0]            bub_q, bub_d;
    logic                  rv_q, rv_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  mis_q, mis_d;
    logic                  ill_q, ill_d;

    logic                  cond_taken;
    logic                  f3_bad;
    logic                  type_any;
    logic                  type_multi;
    logic                  resolve_en;
    logic                  resolved;
    logic                  taken;
    logic                  accept;
    logic [DATA_WIDTH-1:0] target;

    // JALR clears bit 0 of the computed address, so that bit never matters.
    logic unused_alu_lsb;
    assign unused_alu_lsb = ALUResult[0];

    always_comb begin
        cond_taken = 1'b0;
        f3_bad     = 1'b0;
        case (ex_funct3)
            F3_BEQ:  cond_taken = Zero;
            F3_BNE:  cond_taken = ~Zero;
            F3_BLT:  cond_taken = N ^ V;
            F3_BGE:  cond_taken = ~(N ^ V);
            F3_BLTU: cond_taken = C;
            F3_BGEU: cond_taken = ~C;
            default: f3_bad     = 1'b1;
        endcase

        type_any   = ex_is_branch | ex_is_jal | ex_is_jalr;
        type_multi = (ex_is_branch & ex_is_jal) | (ex_is_branch & ex_is_jalr) |
                     (ex_is_jal & ex_is_jalr);
        resolve_en = (state_q == IDLE) && ex_valid;
        resolved   = resolve_en && type_any && !type_multi && !(ex_is_branch && f3_bad);
        taken      = resolved && (ex_is_jal || ex_is_jalr || cond_taken);
        ill_d      = resolve_en && (type_multi || (ex_is_branch && f3_bad));
        target     = ex_is_jalr ? {ALUResult[DATA_WIDTH-1:1], 1'b0} : ex_target;
        accept     = (state_q == REDIRECT) && redirect_ready;
    end

    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        rv_d    = rv_q;
        pc_d    = pc_q;
        mis_d   = mis_q;
        case (state_q)
            IDLE: begin
                if (taken) begin
                    state_d = REDIRECT;
                    rv_d    = 1'b1;
                    pc_d    = target;
                    mis_d   = target[1];
                end
            end
            REDIRECT: begin
                if (redirect_ready) begin
                    rv_d  = 1'b0;
                    mis_d = 1'b0;
                    if (FLUSH_CYCLES == 1) begin
                        state_d = IDLE;
                        bub_d   = 3'd0;
                    end else begin
                        state_d = FLUSH;
                        bub_d   = 3'(FLUSH_CYCLES - 1);
                    end
                end
            end
            FLUSH: begin
                if (bub_q <= 3'd1) begin
                    state_d = IDLE;
                    bub_d   = 3'd0;
                end else begin
                    bub_d = bub_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                bub_d   = 3'd0;
                rv_d    = 1'b0;
                mis_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            bub_q   <= 3'd0;
            rv_q    <= 1'b0;
            pc_q    <= '0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            rv_q    <= rv_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (resolved),
        .count (branch_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_taken_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (taken),
        .count (taken_count)
    );

    assign redirect_valid  = rv_q;
    assign redirect_pc     = pc_q;
    assign target_misalign = mis_q;
    assign stall_ex        = (state_q == REDIRECT);
    // Flush starts combinationally in the accept cycle so IF/ID never sees a wrong-path slot.
    assign flush           = accept || (state_q == FLUSH);
    assign illegal_branch  = ill_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a redirect scoreboard checked at each fetch accept.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_target, ALUResult;
    logic        Zero, N, C, V;
    logic        redirect_valid, redirect_ready, target_misalign;
    logic [31:0] redirect_pc;
    logic        flush, stall_ex, illegal_branch;
    logic [3:0]  branch_count, taken_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        mis;
    } exp_t;
    exp_t sb[$];

    branch_resolve_unit #(.DATA_WIDTH(32), .FLUSH_CYCLES(2), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal),
        .ex_is_jalr(ex_is_jalr), .ex_funct3(ex_funct3), .ex_target(ex_target),
        .ALUResult(ALUResult), .Zero(Zero), .N(N), .C(C), .V(V),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .target_misalign(target_misalign),
        .flush(flush), .stall_ex(stall_ex), .illegal_branch(illegal_branch),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = 3'b000; ex_target = '0; ALUResult = '0;
        Zero = 0; N = 0; C = 0; V = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic mis);
        exp_t e;
        e.pc  = pc;
        e.mis = mis;
        sb.push_back(e);
    endtask

    // Every accepted redirect must match the oldest expected target.
    always @(negedge clk) begin
        if (rst === 1'b0 && redirect_valid === 1'b1 && redirect_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_unexpected observed=%0h expected=none", redirect_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_pc", redirect_pc, e.pc);
                chk("sb_mis", {31'd0, target_misalign}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        redirect_ready = 0;
        rst = 1;
        tick(); tick();
        chk("rst_valid", {31'd0, redirect_valid}, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_flush", {31'd0, flush}, 0);
        chk("rst_stall", {31'd0, stall_ex}, 0);
        chk("rst_ill", {31'd0, illegal_branch}, 0);
        chk("rst_mis", {31'd0, target_misalign}, 0);
        chk("rst_bcnt", {28'd0, branch_count}, 0);
        chk("rst_tcnt", {28'd0, taken_count}, 0);
        rst = 0;

        // 1: BEQ taken, fetch ready immediately
        redirect_ready = 1;
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000; Zero = 1; ex_target = 32'h100;
        push(32'h100, 0);
        tick(); clr();
        chk("beq_valid", {31'd0, redirect_valid}, 1);
        chk("beq_pc", redirect_pc, 32'h100);
        chk("beq_flush_n1", {31'd0, flush}, 1);
        chk("beq_stall", {31'd0, stall_ex}, 1);
        chk("beq_tcnt", {28'd0, taken_count}, 1);
        tick();
        chk("beq_valid_drop", {31'd0, redirect_valid}, 0);
        chk("beq_flush_n2", {31'd0, flush}, 1);
        chk("beq_stall_n2", {31'd0, stall_ex}, 0);
        tick();
        chk("beq_flush_n3", {31'd0, flush}, 0);

        // 2: BLT taken (N^V), then BLTU not taken
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b100; N = 0; V = 1; ex_target = 32'h204;
        push(32'h204, 0);
        tick(); clr();
        chk("blt_valid", {31'd0, redirect_valid}, 1);
        chk("blt_pc", redirect_pc, 32'h204);
        tick(); tick();
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b110; C = 0; ex_target = 32'h300;
        tick(); clr();
        chk("bltu_valid", {31'd0, redirect_valid}, 0);
        chk("bltu_flush", {31'd0, flush}, 0);
        chk("bltu_stall", {31'd0, stall_ex}, 0);
        chk("bltu_bcnt", {28'd0, branch_count}, 3);
        chk("bltu_tcnt", {28'd0, taken_count}, 2);

        // 3: JALR to odd address, fetch stalls for 5 cycles
        redirect_ready = 0;
        ex_valid = 1; ex_is_jalr = 1; ALUResult = 32'h203;
        push(32'h202, 1);
        tick(); clr();
        for (int i = 0; i < 5; i++) begin
            chk("jalr_pc", redirect_pc, 32'h202);
            chk("jalr_mis", {31'd0, target_misalign}, 1);
            chk("jalr_stall", {31'd0, stall_ex}, 1);
            chk("jalr_valid", {31'd0, redirect_valid}, 1);
            chk("jalr_noflush", {31'd0, flush}, 0);
            ex_valid = i[0]; ex_is_jal = 1; ex_target = 32'h400;
            tick();
        end
        clr();
        redirect_ready = 1;
        #1;
        chk("jalr_accept_flush", {31'd0, flush}, 1);
        tick();
        chk("jalr_valid_drop", {31'd0, redirect_valid}, 0);
        chk("jalr_mis_drop", {31'd0, target_misalign}, 0);
        chk("jalr_flush2", {31'd0, flush}, 1);
        tick();
        chk("jalr_bcnt", {28'd0, branch_count}, 4);
        chk("jalr_tcnt", {28'd0, taken_count}, 3);

        // 4: reserved funct3 and multiple type bits
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b011; Zero = 1;
        tick(); clr();
        chk("ill_pulse", {31'd0, illegal_branch}, 1);
        chk("ill_valid", {31'd0, redirect_valid}, 0);
        chk("ill_bcnt", {28'd0, branch_count}, 4);
        chk("ill_tcnt", {28'd0, taken_count}, 3);
        tick();
        chk("ill_end", {31'd0, illegal_branch}, 0);
        ex_valid = 1; ex_is_branch = 1; ex_is_jal = 1; ex_funct3 = 3'b000; Zero = 1;
        ex_target = 32'h500;
        tick(); clr();
        chk("multi_pulse", {31'd0, illegal_branch}, 1);
        chk("multi_valid", {31'd0, redirect_valid}, 0);
        chk("multi_bcnt", {28'd0, branch_count}, 4);
        tick();

        // 5: reset in REDIRECT wins even with fetch ready
        redirect_ready = 0;
        ex_valid = 1; ex_is_jal = 1; ex_target = 32'h300;
        tick(); clr();
        chk("pre_rst_valid", {31'd0, redirect_valid}, 1);
        chk("pre_rst_pc", redirect_pc, 32'h300);
        rst = 1; redirect_ready = 1;
        tick();
        chk("mid_rst_valid", {31'd0, redirect_valid}, 0);
        chk("mid_rst_stall", {31'd0, stall_ex}, 0);
        chk("mid_rst_flush", {31'd0, flush}, 0);
        chk("mid_rst_pc", redirect_pc, 0);
        chk("mid_rst_bcnt", {28'd0, branch_count}, 0);
        chk("mid_rst_tcnt", {28'd0, taken_count}, 0);
        rst = 0;
        tick();
        chk("post_rst_valid", {31'd0, redirect_valid}, 0);

        // 6: 20 taken JALs saturate both 4-bit counters
        for (int i = 0; i < 20; i++) begin
            ex_valid = 1; ex_is_jal = 1; ex_target = 32'h1000 + 32'(i) * 4;
            push(32'h1000 + 32'(i) * 4, 0);
            tick(); clr();
            if (i == 14) begin
                chk("sat_bcnt_15th", {28'd0, branch_count}, 15);
                chk("sat_tcnt_15th", {28'd0, taken_count}, 15);
            end
            tick(); tick();
        end
        chk("sat_bcnt", {28'd0, branch_count}, 15);
        chk("sat_tcnt", {28'd0, taken_count}, 15);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
